// File: rtl/pc_unit.sv
// ============================================================================
// Module   : pc_unit
// Brief    : Program-counter unit with next-PC selection, stall-time redirect
//            buffering, misaligned-target fault and fetch handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_ADDR = '0,
    parameter int              INC        = 4,
    parameter int              ALIGN_BITS = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_stall,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_target,
    input  logic            i_trap_valid,
    input  logic [XLEN-1:0] i_trap_vec,
    input  logic            i_fetch_ready,
    output logic [XLEN-1:0] o_pc_curr,
    output logic            o_pc_valid,
    output logic            o_pc_misaligned,
    output logic [XLEN-1:0] o_fault_addr
);

    localparam logic [1:0] c_ST_BOOT  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_FAULT = 2'd2;

    // Mask of the low bits that must be zero; shift form also covers ALIGN_BITS=0.
    localparam logic [XLEN-1:0] c_ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);
    localparam logic [XLEN-1:0] c_INC        = XLEN'(INC);

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_pend_valid;
    logic [XLEN-1:0] r_pend_target;
    logic            r_misaligned;
    logic [XLEN-1:0] r_fault_addr;

    logic [1:0]      w_state_nxt;
    logic [XLEN-1:0] w_pc_nxt;
    logic            w_pend_valid_nxt;
    logic [XLEN-1:0] w_pend_target_nxt;
    logic            w_misaligned_nxt;
    logic [XLEN-1:0] w_fault_addr_nxt;

    logic [XLEN-1:0] w_trap_pc;
    logic [XLEN-1:0] w_apply_tgt;
    logic            w_apply_misal;

    assign w_trap_pc     = i_trap_vec & ~c_ALIGN_MASK;
    // A fresh redirect always wins over the buffered one.
    assign w_apply_tgt   = i_redirect_valid ? i_redirect_target : r_pend_target;
    assign w_apply_misal = |(w_apply_tgt & c_ALIGN_MASK);

    // State and datapath register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_BOOT;
            r_pc          <= RESET_ADDR;
            r_pend_valid  <= 1'b0;
            r_pend_target <= '0;
            r_misaligned  <= 1'b0;
            r_fault_addr  <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_pend_valid  <= w_pend_valid_nxt;
            r_pend_target <= w_pend_target_nxt;
            r_misaligned  <= w_misaligned_nxt;
            r_fault_addr  <= w_fault_addr_nxt;
        end
    end

    // Next-state and next-PC selection
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_pend_valid_nxt  = r_pend_valid;
        w_pend_target_nxt = r_pend_target;
        w_misaligned_nxt  = r_misaligned;
        w_fault_addr_nxt  = r_fault_addr;

        case (r_state)
            c_ST_BOOT: begin
                w_state_nxt = c_ST_RUN;
                if (i_trap_valid) begin
                    w_pc_nxt         = w_trap_pc;
                    w_pend_valid_nxt = 1'b0;
                end
            end

            c_ST_RUN: begin
                if (i_trap_valid) begin
                    w_pc_nxt         = w_trap_pc;
                    w_pend_valid_nxt = 1'b0;
                end else if (i_redirect_valid && i_stall) begin
                    w_pend_target_nxt = i_redirect_target;
                    w_pend_valid_nxt  = 1'b1;
                end else if (!i_stall && (i_redirect_valid || r_pend_valid)) begin
                    w_pend_valid_nxt = 1'b0;
                    if (w_apply_misal) begin
                        w_state_nxt      = c_ST_FAULT;
                        w_misaligned_nxt = 1'b1;
                        w_fault_addr_nxt = w_apply_tgt;
                    end else begin
                        w_pc_nxt = w_apply_tgt;
                    end
                end else if (i_fetch_ready && !i_stall) begin
                    w_pc_nxt = r_pc + c_INC;
                end
            end

            c_ST_FAULT: begin
                if (i_trap_valid) begin
                    w_state_nxt      = c_ST_RUN;
                    w_pc_nxt         = w_trap_pc;
                    w_misaligned_nxt = 1'b0;
                    w_pend_valid_nxt = 1'b0;
                end
            end

            default: begin
                w_state_nxt = c_ST_BOOT;
            end
        endcase
    end

    // Outputs depend only on registered state
    always_comb begin
        o_pc_valid      = (r_state == c_ST_RUN);
        o_pc_curr       = r_pc;
        o_pc_misaligned = r_misaligned;
        o_fault_addr    = r_fault_addr;
    end

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// ============================================================================
// Module   : tb_pc_unit
// Brief    : Directed self-checking bench for pc_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pc_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_valid;
    logic [31:0] trap_vec;
    logic        fetch_ready;
    logic [31:0] pc_curr;
    logic        pc_valid;
    logic        pc_misaligned;
    logic [31:0] fault_addr;

    int n_tests = 0;
    int n_fail  = 0;

    pc_unit #(
        .XLEN       (32),
        .RESET_ADDR (32'h0000_0000),
        .INC        (4),
        .ALIGN_BITS (2)
    ) u_dut (
        .clk               (clk),
        .rst               (rst),
        .i_stall           (stall),
        .i_redirect_valid  (redirect_valid),
        .i_redirect_target (redirect_target),
        .i_trap_valid      (trap_valid),
        .i_trap_vec        (trap_vec),
        .i_fetch_ready     (fetch_ready),
        .o_pc_curr         (pc_curr),
        .o_pc_valid        (pc_valid),
        .o_pc_misaligned   (pc_misaligned),
        .o_fault_addr      (fault_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic e_valid,
                           input logic e_mis, input logic [31:0] e_fault);
        chk({tag, ".pc"},    pc_curr,               e_pc);
        chk({tag, ".valid"}, {31'd0, pc_valid},      {31'd0, e_valid});
        chk({tag, ".mis"},   {31'd0, pc_misaligned}, {31'd0, e_mis});
        chk({tag, ".fault"}, fault_addr,            e_fault);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        trap_valid = 1'b0; trap_vec = '0; fetch_ready = 1'b0;

        // 1: reset, BOOT, then sequential stepping
        step(); step();
        chk_all("reset", 32'h0, 1'b0, 1'b0, 32'h0);
        rst = 1'b0; fetch_ready = 1'b1;
        #1;
        chk_all("boot", 32'h0, 1'b0, 1'b0, 32'h0);
        step(); chk_all("run0", 32'h0, 1'b1, 1'b0, 32'h0);
        step(); chk("seq4", pc_curr, 32'h4);
        step(); chk("seq8", pc_curr, 32'h8);
        step(); chk("seqC", pc_curr, 32'hC);

        // 2: wrap at top of address space
        fetch_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        step(); chk("redir_top", pc_curr, 32'hFFFF_FFFC);
        redirect_valid = 1'b0; fetch_ready = 1'b1;
        step(); chk_all("wrap", 32'h0, 1'b1, 1'b0, 32'h0);
        fetch_ready = 1'b0;

        // 3: redirects during stall, newest wins
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h100;
        step(); chk("stall_r1", pc_curr, 32'h0);
        redirect_target = 32'h200;
        step(); chk("stall_r2", pc_curr, 32'h0);
        redirect_valid = 1'b0;
        step(); chk("stall_hold", pc_curr, 32'h0);
        stall = 1'b0;
        step(); chk("pend_apply", pc_curr, 32'h200);
        step(); chk("pend_once", pc_curr, 32'h200);

        // 4: trap beats redirect and clears pend
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h300;
        step(); chk("pend300", pc_curr, 32'h200);
        trap_valid = 1'b1; trap_vec = 32'h83; redirect_target = 32'h500;
        step(); chk("trap_win", pc_curr, 32'h80);
        trap_valid = 1'b0; redirect_valid = 1'b0; stall = 1'b0;
        step(); chk("trap_clr_pend", pc_curr, 32'h80);

        // 5: misaligned redirect faults; only a trap exits
        redirect_valid = 1'b1; redirect_target = 32'h102;
        step(); chk_all("fault", 32'h80, 1'b0, 1'b1, 32'h102);
        redirect_target = 32'h200; fetch_ready = 1'b1;
        step(); chk_all("fault_ign", 32'h80, 1'b0, 1'b1, 32'h102);
        redirect_valid = 1'b0; trap_valid = 1'b1; trap_vec = 32'h40;
        step(); chk_all("fault_exit", 32'h40, 1'b1, 1'b0, 32'h102);
        trap_valid = 1'b0;
        step(); chk("run_again", pc_curr, 32'h44);

        // misaligned buffered target faults when applied
        fetch_ready = 1'b0; stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h46;
        step(); chk("pend46", pc_curr, 32'h44);
        stall = 1'b0; redirect_valid = 1'b0;
        step(); chk_all("pend_fault", 32'h44, 1'b0, 1'b1, 32'h46);
        trap_valid = 1'b1; trap_vec = 32'h0;
        step(); chk_all("pend_exit", 32'h0, 1'b1, 1'b0, 32'h46);
        trap_valid = 1'b0; fetch_ready = 1'b1;
        step(); chk("step4", pc_curr, 32'h4);

        // 6: fetch not ready holds; reset mid-stall drops pend
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); chk("hold", pc_curr, 32'h4);
        end
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h700;
        step(); chk("pend700", pc_curr, 32'h4);
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        step(); chk_all("mid_rst", 32'h0, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        step(); chk_all("rst_boot", 32'h0, 1'b1, 1'b0, 32'h0);
        step(); chk("pend_gone", pc_curr, 32'h0);

        // trap honoured in BOOT
        rst = 1'b1;
        step();
        rst = 1'b0; trap_valid = 1'b1; trap_vec = 32'h1F3;
        step(); chk_all("boot_trap", 32'h1F0, 1'b1, 1'b0, 32'h0);
        trap_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
